ptw_req_arbiter: RTL and testbench
==================================

# ptw_req_arbiter

Parametrised N-channel arbiter for page-table-walker requests. It merges per-requester (20-bit address, need_gpa) request streams onto one PTW request port. It generalises the existing two-input fixed-priority combinational arbiter in three ways: configurable channel count, selectable fixed-priority or round-robin arbitration, and a registered one-entry output stage that cuts the combinational valid/ready path between requesters and the PTW.

## Interface
Parameters:
- N, default 2: number of input channels, 2..8.
- ADDR_W, default 20: request address width.
- RR, default 0: arbitration mode. 0 = fixed priority (channel 0 highest). 1 = round-robin.
- CHOSEN_W, derived: max(1, clog2(N)). Not overridable.

Ports (name, direction, width, meaning):
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- io_in_valid, in, N: per-channel request valid.
- io_in_ready, out, N: per-channel accept.
- io_in_bits_valid, in, N: per-channel payload valid flag.
- io_in_addr, in, N*ADDR_W: channel i occupies bits [i*ADDR_W +: ADDR_W].
- io_in_need_gpa, in, N: per-channel need_gpa flag.
- io_out_valid, out, 1: output register holds a request.
- io_out_ready, in, 1: PTW accepts the request.
- io_out_bits_valid, out, 1: registered payload valid flag.
- io_out_addr, out, ADDR_W: registered address.
- io_out_need_gpa, out, 1: registered need_gpa.
- io_chosen, out, CHOSEN_W: index of the channel whose request is held.

## Operation
- State:
  - one-entry output register: full flag, bits_valid, addr, need_gpa, chosen.
  - round-robin pointer ptr, CHOSEN_W bits. Present only when RR=1.
- load_en = !full | io_out_ready. The stage can accept whenever it is empty or is being drained in the same cycle.
- Grant g, combinational over io_in_valid:
  - RR=0: lowest valid index wins.
  - RR=1: first valid index found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Wrap is mod N, including non-power-of-two N.
- io_in_ready[i] = load_en & any_valid & (i == g). At most one ready is high per cycle. A ready never asserts for a channel whose valid is low.
- Accept (io_in_valid[g] & io_in_ready[g]):
  - The register loads bits_valid[g], addr[g], need_gpa[g] and chosen = g.
  - full <= 1.
  - RR=1: ptr <= (g+1) mod N, wrapping to 0 when g = N-1.
- Drain (io_out_valid & io_out_ready) with no accept in the same cycle: full <= 0. Payload registers hold their last value.
- Simultaneous drain and accept: the new request replaces the old one and full stays 1. This sustains one request per cycle.
- io_out_ready while the stage is empty has no effect.
- RR=0: ptr is unused and stays 0.
- Payload and chosen registers load only on accept. There is no gating on io_in_bits_valid; that flag is carried through unchanged.

## Timing
- Latency: an accept in cycle t makes io_out_valid high from cycle t+1. There is no combinational path from io_in_* to io_out_*.
- Combinational paths:
  - io_out_ready to io_in_ready.
  - io_in_valid to io_in_ready.
- Throughput: 1 request/cycle while io_out_ready stays high.
- Hold rule: io_out_valid and all io_out_* bits stay stable while io_out_valid & !io_out_ready.
- Reset: asynchronous assertion immediately drives the following to 0:
  - full, io_out_valid, io_out_bits_valid, io_out_addr, io_out_need_gpa, io_chosen, ptr.
  - all io_in_ready, because full=0 but reset forces ready low.
- Reset mid-operation: a held request is discarded and is not replayed.
- First cycle after reset deassertion: normal arbitration, with ptr=0.

## Test plan
- Single request: N=2, RR=0. Channel 1 sends addr=0x0ABCD, need_gpa=1, io_out_ready=1. Required: io_in_ready[1]=1 in the same cycle; next cycle io_out_valid=1, io_out_addr=0x0ABCD, io_out_need_gpa=1, io_chosen=1.
- Fixed priority: N=4, RR=0, all channels valid continuously, io_out_ready=1. Required: io_chosen=0 on every output cycle and io_in_ready[3:1]=0 throughout.
- Round-robin wrap: N=3, RR=1, all channels valid for 6 accepts. Required: chosen sequence 0,1,2,0,1,2 and ptr back at 0.
- Backpressure: io_out_ready=0 for 3 cycles while the stage is full and channel 0 is valid with a new addr. Required: io_in_ready=0 and the output holds the old addr unchanged. When io_out_ready rises, the drain and the new accept happen in the same cycle, and the new addr appears in the next cycle.
- Back-to-back: io_out_ready held high, channel 2 valid for 4 consecutive cycles with addr 1,2,3,4. Required: io_out_valid high for 4 consecutive cycles showing addr 1..4 in order.
- Async reset mid-hold: assert reset between clock edges while full=1. Required: io_out_valid and io_chosen drop to 0 immediately; after release the first accept goes to the lowest valid index when RR=1.

Source files
------------

// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter: N-channel page-table-walker request arbiter.
// Fixed-priority or round-robin grant feeding a one-entry registered output stage,
// so no combinational path runs from the requesters to the PTW request port.
module ptw_req_arbiter #(
  parameter int unsigned N      = 2,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned RR     = 0,
  localparam int unsigned CHOSEN_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          io_in_valid,
  output logic [N-1:0]          io_in_ready,
  input  logic [N-1:0]          io_in_bits_valid,
  input  logic [N*ADDR_W-1:0]   io_in_addr,
  input  logic [N-1:0]          io_in_need_gpa,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic                  io_out_bits_valid,
  output logic [ADDR_W-1:0]     io_out_addr,
  output logic                  io_out_need_gpa,
  output logic [CHOSEN_W-1:0]   io_chosen
);

  logic                full_q;
  logic                bits_valid_q;
  logic                need_gpa_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CHOSEN_W-1:0] chosen_q;
  logic [CHOSEN_W-1:0] ptr_q;

  logic                any_valid;
  logic                load_en;
  logic                accept;
  logic                hi_found;
  logic [CHOSEN_W-1:0] hi_idx;
  logic [CHOSEN_W-1:0] lo_idx;
  logic [CHOSEN_W-1:0] grant;
  logic                sel_bits_valid;
  logic                sel_need_gpa;
  logic [ADDR_W-1:0]   sel_addr;

  // Grant: lowest valid index at or above ptr, else lowest valid index overall (wraps mod N).
  // With ptr pinned at 0 this degenerates to plain fixed priority.
  always_comb begin
    any_valid = |io_in_valid;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (io_in_valid[i]) begin
        lo_idx = CHOSEN_W'(i);
        if (CHOSEN_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = CHOSEN_W'(i);
        end
      end
    end
    grant = hi_found ? hi_idx : lo_idx;
  end

  // Stage can take a request when empty or being drained this cycle; reset forces ready low.
  assign load_en = ~full_q | io_out_ready;
  assign accept  = load_en & any_valid & ~reset;

  // Per-channel ready and payload mux for the granted channel.
  always_comb begin
    io_in_ready    = '0;
    sel_bits_valid = 1'b0;
    sel_need_gpa   = 1'b0;
    sel_addr       = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant == CHOSEN_W'(i)) begin
        io_in_ready[i] = accept;
        sel_bits_valid = io_in_bits_valid[i];
        sel_need_gpa   = io_in_need_gpa[i];
        sel_addr       = io_in_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Output register: load on accept (replacing any draining entry), clear full on drain only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q       <= 1'b0;
      bits_valid_q <= 1'b0;
      need_gpa_q   <= 1'b0;
      addr_q       <= '0;
      chosen_q     <= '0;
    end else if (accept) begin
      full_q       <= 1'b1;
      bits_valid_q <= sel_bits_valid;
      need_gpa_q   <= sel_need_gpa;
      addr_q       <= sel_addr;
      chosen_q     <= grant;
    end else if (io_out_ready) begin
      full_q       <= 1'b0;
    end
  end

  if (RR != 0) begin : g_rr
    // Round-robin pointer: move to the channel after the one just accepted.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        ptr_q <= '0;
      end else if (accept) begin
        ptr_q <= (grant == CHOSEN_W'(N - 1)) ? '0 : grant + 1'b1;
      end
    end
  end else begin : g_fixed
    assign ptr_q = '0;
  end

  assign io_out_valid      = full_q;
  assign io_out_bits_valid = bits_valid_q;
  assign io_out_addr       = addr_q;
  assign io_out_need_gpa   = need_gpa_q;
  assign io_chosen         = chosen_q;

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Bench for ptw_req_arbiter: a 4-channel fixed-priority instance and a 3-channel round-robin
// instance share one stimulus stream and are both checked against a queue-level model.
module tb_ptw_req_arbiter;

  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_valid;
  logic [3:0]    in_bv;
  logic [3:0]    in_need;
  logic [AW-1:0] in_addr [4];
  logic          out_ready;

  logic [3:0]    a_ready;
  logic          a_ovalid, a_obv, a_oneed;
  logic [AW-1:0] a_oaddr;
  logic [1:0]    a_chosen;
  logic [2:0]    b_ready;
  logic          b_ovalid, b_obv, b_oneed;
  logic [AW-1:0] b_oaddr;
  logic [1:0]    b_chosen;

  logic [4*AW-1:0] a_addr_bus;
  logic [3*AW-1:0] b_addr_bus;
  assign a_addr_bus = {in_addr[3], in_addr[2], in_addr[1], in_addr[0]};
  assign b_addr_bus = {in_addr[2], in_addr[1], in_addr[0]};

  always #5 clk = ~clk;

  ptw_req_arbiter #(.N(4), .ADDR_W(AW), .RR(0)) dut_fp (
    .clock(clk), .reset(rst),
    .io_in_valid(in_valid), .io_in_ready(a_ready), .io_in_bits_valid(in_bv),
    .io_in_addr(a_addr_bus), .io_in_need_gpa(in_need),
    .io_out_valid(a_ovalid), .io_out_ready(out_ready), .io_out_bits_valid(a_obv),
    .io_out_addr(a_oaddr), .io_out_need_gpa(a_oneed), .io_chosen(a_chosen)
  );

  ptw_req_arbiter #(.N(3), .ADDR_W(AW), .RR(1)) dut_rr (
    .clock(clk), .reset(rst),
    .io_in_valid(in_valid[2:0]), .io_in_ready(b_ready), .io_in_bits_valid(in_bv[2:0]),
    .io_in_addr(b_addr_bus), .io_in_need_gpa(in_need[2:0]),
    .io_out_valid(b_ovalid), .io_out_ready(out_ready), .io_out_bits_valid(b_obv),
    .io_out_addr(b_oaddr), .io_out_need_gpa(b_oneed), .io_chosen(b_chosen)
  );

  // Reference model: index 0 = fixed-priority instance, 1 = round-robin instance.
  int            nch [2] = '{4, 3};
  bit            rrm [2] = '{1'b0, 1'b1};
  bit            m_full [2];
  bit            m_bv [2];
  bit            m_need [2];
  logic [AW-1:0] m_addr [2];
  int            m_chosen [2];
  int            m_ptr [2];
  int            m_g [2];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int d);
    for (int k = 0; k < nch[d]; k++) begin
      int idx;
      idx = (m_ptr[d] + k) % nch[d];
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 0; m_bv[d] = 0; m_need[d] = 0; m_addr[d] = '0;
      m_chosen[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic apply(input logic [3:0] v, input logic ordy, input logic [AW-1:0] addr,
                       input logic [3:0] need, input logic [3:0] bv);
    in_valid = v; out_ready = ordy; in_need = need; in_bv = bv;
    for (int i = 0; i < 4; i++) in_addr[i] = addr;
  endtask

  // Combinational ready check, shortly before the next rising edge.
  task automatic step_pre();
    logic [3:0] er;
    #2;
    for (int d = 0; d < 2; d++) begin
      m_g[d] = -1;
      er = '0;
      if (!m_full[d] || out_ready) m_g[d] = pick(d);
      if (m_g[d] >= 0) er[m_g[d]] = 1'b1;
      if (d == 0) chk("fp_ready", a_ready, er);
      else        chk("rr_ready", {1'b0, b_ready}, er);
    end
  endtask

  // Clock edge, model update, then registered output check 1 time unit later.
  task automatic step_post();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (m_g[d] >= 0) begin
        m_full[d] = 1; m_bv[d] = in_bv[m_g[d]]; m_need[d] = in_need[m_g[d]];
        m_addr[d] = in_addr[m_g[d]]; m_chosen[d] = m_g[d];
        if (rrm[d]) m_ptr[d] = (m_g[d] + 1) % nch[d];
      end else if (out_ready) begin
        m_full[d] = 0;
      end
    end
    #1;
    chk("fp_out_valid", a_ovalid, m_full[0]);
    chk("fp_out_addr", a_oaddr, m_addr[0]);
    chk("fp_out_need", a_oneed, m_need[0]);
    chk("fp_out_bv", a_obv, m_bv[0]);
    chk("fp_chosen", a_chosen, m_chosen[0]);
    chk("rr_out_valid", b_ovalid, m_full[1]);
    chk("rr_out_addr", b_oaddr, m_addr[1]);
    chk("rr_out_need", b_oneed, m_need[1]);
    chk("rr_out_bv", b_obv, m_bv[1]);
    chk("rr_chosen", b_chosen, m_chosen[1]);
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  typedef struct {
    logic [3:0]    valid;
    logic          ordy;
    logic [AW-1:0] addr;
    logic [3:0]    e_ready;
    logic          e_ovalid;
    logic [1:0]    e_chosen;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t tbl [12];
  int   rr_exp [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    // Directed vectors for the fixed-priority instance; all channels carry the same addr.
    tbl[0]  = '{4'b0010, 1'b1, 20'h0ABCD, 4'b0010, 1'b1, 2'd1, 20'h0ABCD};
    tbl[1]  = '{4'b1111, 1'b1, 20'h00001, 4'b0001, 1'b1, 2'd0, 20'h00001};
    tbl[2]  = '{4'b1111, 1'b1, 20'h00002, 4'b0001, 1'b1, 2'd0, 20'h00002};
    tbl[3]  = '{4'b0001, 1'b0, 20'h00003, 4'b0000, 1'b1, 2'd0, 20'h00002};
    tbl[4]  = '{4'b0001, 1'b0, 20'h00004, 4'b0000, 1'b1, 2'd0, 20'h00002};
    tbl[5]  = '{4'b0001, 1'b0, 20'h00005, 4'b0000, 1'b1, 2'd0, 20'h00002};
    tbl[6]  = '{4'b0001, 1'b1, 20'h00006, 4'b0001, 1'b1, 2'd0, 20'h00006};
    tbl[7]  = '{4'b0000, 1'b1, 20'h00007, 4'b0000, 1'b0, 2'd0, 20'h00006};
    tbl[8]  = '{4'b0000, 1'b1, 20'h00008, 4'b0000, 1'b0, 2'd0, 20'h00006};
    tbl[9]  = '{4'b1000, 1'b0, 20'h0FFFF, 4'b1000, 1'b1, 2'd3, 20'h0FFFF};
    tbl[10] = '{4'b0100, 1'b0, 20'h12345, 4'b0000, 1'b1, 2'd3, 20'h0FFFF};
    tbl[11] = '{4'b0100, 1'b1, 20'h12345, 4'b0100, 1'b1, 2'd2, 20'h12345};

    // Reset state.
    rst = 1'b1;
    apply(4'b0000, 1'b0, '0, 4'b0000, 4'b0000);
    model_reset();
    #1;
    chk("rst_fp_valid", a_ovalid, 0);
    chk("rst_fp_ready", a_ready, 0);
    chk("rst_fp_addr", a_oaddr, 0);
    chk("rst_fp_chosen", a_chosen, 0);
    chk("rst_rr_valid", b_ovalid, 0);
    chk("rst_rr_ready", b_ready, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin wrap over 3 channels, then ptr back at 0.
    for (int i = 0; i < 7; i++) begin
      apply(4'b1111, 1'b1, AW'(i + 16), 4'b0101, 4'b0011);
      step();
      chk("rr_wrap_seq", b_chosen, (i < 6) ? rr_exp[i] : 0);
    end

    // Table-driven directed vectors.
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].valid, tbl[i].ordy, tbl[i].addr, 4'b1010, 4'b1111);
      step_pre();
      chk("tbl_ready", a_ready, tbl[i].e_ready);
      step_post();
      chk("tbl_out_valid", a_ovalid, tbl[i].e_ovalid);
      chk("tbl_chosen", a_chosen, tbl[i].e_chosen);
      chk("tbl_addr", a_oaddr, tbl[i].e_addr);
      if (i == 0) chk("tbl_need", a_oneed, 1);
    end

    // Back-to-back on channel 2.
    for (int i = 1; i <= 4; i++) begin
      apply(4'b0100, 1'b1, AW'(i), 4'b0000, 4'b0100);
      step();
      chk("b2b_valid", a_ovalid, 1);
      chk("b2b_addr", a_oaddr, i);
      chk("b2b_chosen", a_chosen, 2);
    end

    // Fixed priority under continuous contention.
    for (int i = 0; i < 5; i++) begin
      apply(4'b1111, 1'b1, AW'(32'h100 + i), 4'b1111, 4'b1111);
      step();
      chk("fp_chosen0", a_chosen, 0);
      chk("fp_hi_ready", a_ready[3:1], 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_bv     = 4'($urandom);
      in_need   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) in_addr[c] = AW'($urandom);
      step();
    end

    // Async reset while a request is held; RR ptr is left at 2 beforehand.
    apply(4'b0010, 1'b1, 20'h0AAAA, 4'b0000, 4'b0010);
    step();
    apply(4'b0000, 1'b0, 20'h0BBBB, 4'b0000, 4'b0000);
    step();
    chk("hold_full", b_ovalid, 1);
    in_valid = 4'b1111;
    #2 rst = 1'b1;
    #1;
    chk("arst_fp_valid", a_ovalid, 0);
    chk("arst_fp_chosen", a_chosen, 0);
    chk("arst_fp_ready", a_ready, 0);
    chk("arst_rr_valid", b_ovalid, 0);
    chk("arst_rr_chosen", b_chosen, 0);
    chk("arst_rr_ready", b_ready, 0);
    model_reset();
    #1 rst = 1'b0;
    apply(4'b0110, 1'b1, 20'h0CCCC, 4'b0000, 4'b0110);
    step();
    chk("post_rst_rr_chosen", b_chosen, 1);
    chk("post_rst_fp_chosen", a_chosen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
